// File: rtl/id_ex_skid_stage.sv
// Decode->execute elastic register: 1-cycle latency, 1 entry/cycle streaming, 2-entry skid so in_ready
// is purely registered (!skid_valid) and never combinationally depends on out_ready or flush.
module id_ex_skid_stage #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic   in_fire;
  logic   out_fire;
  entry_t in_entry;

  assign in_entry = '{data: in_data, ctrl: in_ctrl};
  assign in_ready = !skid_vld_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_vld_q && out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    if (!main_vld_q) begin
      if (in_fire) begin
        main_vld_d = 1'b1;
        main_d     = in_entry;
      end
    end else if (out_fire) begin
      // Skid is older than anything upstream, so it refills main first.
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d     = in_entry;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_d     = in_entry;
    end

    // Payload registers may still load on flush; only the valid bits matter.
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end

    if (main_vld_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = main_vld_q;
  assign out_data  = main_q.data;
  // Bubbles must never leak a stale regwrite/memwrite downstream.
  assign out_ctrl  = main_vld_q ? main_q.ctrl : '0;
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: scoreboard queue of expected outputs plus probe queue
// of state checks, both drained by a single negedge monitor.
module tb_id_ex_skid_stage;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 11;
  localparam int CNT_W  = 4;

  localparam int SEL_OVLD = 0;
  localparam int SEL_IRDY = 1;
  localparam int SEL_CTRL = 2;
  localparam int SEL_OCC  = 3;
  localparam int SEL_STC  = 4;
  localparam int SEL_DATA = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  id_ex_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } exp_t;

  typedef struct {
    string             tag;
    int                sel;
    logic [DATA_W-1:0] exp;
  } probe_t;

  exp_t   sb_q[$];
  probe_t probe_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     done   = 1'b0;

  function automatic logic [DATA_W-1:0] mkdata(input logic [CTRL_W-1:0] c);
    return {c, 79'h0, c ^ 11'h5A5};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = mkdata(c);
  endtask

  task automatic expect_out(input logic [CTRL_W-1:0] c);
    exp_t e;
    e.c = c;
    e.d = mkdata(c);
    sb_q.push_back(e);
  endtask

  task automatic probe(input string tag, input int sel, input logic [DATA_W-1:0] exp);
    probe_t p;
    p.tag = tag;
    p.sel = sel;
    p.exp = exp;
    probe_q.push_back(p);
  endtask

  // Monitor: sole owner of the check/error counters.
  initial begin
    exp_t              e;
    probe_t            p;
    logic [DATA_W-1:0] act;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got ctrl=%0h data=%0h, required none", out_ctrl, out_data);
        end else begin
          e = sb_q.pop_front();
          if (out_ctrl !== e.c || out_data !== e.d) begin
            errors++;
            $display("FAIL out_order got ctrl=%0h data=%0h, required ctrl=%0h data=%0h",
                     out_ctrl, out_data, e.c, e.d);
          end
        end
      end
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        case (p.sel)
          SEL_OVLD: act = DATA_W'(out_valid);
          SEL_IRDY: act = DATA_W'(in_ready);
          SEL_CTRL: act = DATA_W'(out_ctrl);
          SEL_OCC:  act = DATA_W'(occupancy);
          SEL_STC:  act = DATA_W'(stall_cnt);
          default:  act = out_data;
        endcase
        checks++;
        if (act !== p.exp) begin
          errors++;
          $display("FAIL %s got %0h, required %0h", p.tag, act, p.exp);
        end
      end
      if (done) begin
        checks++;
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL missing_outputs got %0d undelivered, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);

    probe("rst_out_valid", SEL_OVLD, 0);
    probe("rst_in_ready",  SEL_IRDY, 1);
    probe("rst_out_ctrl",  SEL_CTRL, 0);
    probe("rst_occupancy", SEL_OCC,  0);
    probe("rst_stall_cnt", SEL_STC,  0);
    probe("rst_out_data",  SEL_DATA, 0);
    #12;
    rst = 1'b0;
    step();

    // Streaming: each ctrl shows up one cycle after it is offered.
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, CTRL_W'(i));
      expect_out(CTRL_W'(i));
      step();
      probe("stream_ctrl",  SEL_CTRL, DATA_W'(i));
      probe("stream_occ",   SEL_OCC,  1);
      probe("stream_stall", SEL_STC,  0);
    end
    drive(1'b0, '0);
    step();
    probe("stream_drained_occ", SEL_OCC, 0);

    // Bubble masking after a full-control entry.
    drive(1'b1, 11'h7FF);
    expect_out(11'h7FF);
    step();
    probe("bubble_live_ctrl", SEL_CTRL, 11'h7FF);
    drive(1'b0, '0);
    step();
    probe("bubble_valid", SEL_OVLD, 0);
    probe("bubble_ctrl",  SEL_CTRL, 0);
    step();
    probe("bubble_ctrl_idle", SEL_CTRL, 0);

    // Stall/skid: A, then B with out_ready low, C waits upstream.
    drive(1'b1, 11'h0A1);
    expect_out(11'h0A1);
    step();
    drive(1'b1, 11'h0A2);
    expect_out(11'h0A2);
    out_ready = 1'b0;
    step();
    probe("skid_occ",      SEL_OCC,  2);
    probe("skid_in_ready", SEL_IRDY, 0);
    probe("skid_main",     SEL_CTRL, 11'h0A1);
    probe("skid_stall1",   SEL_STC,  1);
    drive(1'b1, 11'h0A3);
    expect_out(11'h0A3);
    step();
    probe("skid_hold_main", SEL_CTRL, 11'h0A1);
    probe("skid_stall2",    SEL_STC,  2);
    step();
    out_ready = 1'b1;
    step();
    probe("release_main_b", SEL_CTRL, 11'h0A2);
    probe("release_occ",    SEL_OCC,  1);
    probe("release_irdy",   SEL_IRDY, 1);
    probe("release_stall",  SEL_STC,  3);
    step();
    probe("release_main_c", SEL_CTRL, 11'h0A3);
    drive(1'b0, '0);
    step();
    probe("release_empty", SEL_OCC, 0);

    // Flush with both entries held; the 0x7FF offered alongside must vanish.
    out_ready = 1'b0;
    drive(1'b1, 11'h0B1);
    step();
    drive(1'b1, 11'h0B2);
    step();
    probe("flush_pre_occ", SEL_OCC, 2);
    drive(1'b1, 11'h7FF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    probe("flush_valid", SEL_OVLD, 0);
    probe("flush_ctrl",  SEL_CTRL, 0);
    probe("flush_occ",   SEL_OCC,  0);
    probe("flush_irdy",  SEL_IRDY, 1);
    probe("flush_stall", SEL_STC,  5);
    out_ready = 1'b1;
    step();

    // Flush while main delivers and a new input is accepted and dropped.
    drive(1'b1, 11'h0C1);
    expect_out(11'h0C1);
    step();
    drive(1'b1, 11'h7FF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    probe("flush2_valid", SEL_OVLD, 0);
    probe("flush2_occ",   SEL_OCC,  0);
    step();

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 11'h0D1);
    step();
    drive(1'b1, 11'h0D2);
    step();
    drive(1'b0, '0);
    probe("arst_pre_occ", SEL_OCC, 2);
    step();
    #1;
    rst = 1'b1;
    probe("arst_valid", SEL_OVLD, 0);
    probe("arst_occ",   SEL_OCC,  0);
    probe("arst_irdy",  SEL_IRDY, 1);
    probe("arst_ctrl",  SEL_CTRL, 0);
    probe("arst_data",  SEL_DATA, 0);
    probe("arst_stall", SEL_STC,  0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    drive(1'b1, 11'h0E1);
    expect_out(11'h0E1);
    step();
    probe("arst_latency_valid", SEL_OVLD, 1);
    probe("arst_latency_ctrl",  SEL_CTRL, 11'h0E1);
    drive(1'b0, '0);
    step();

    // Saturation of the 4-bit stall counter.
    out_ready = 1'b0;
    drive(1'b1, 11'h0F1);
    expect_out(11'h0F1);
    step();
    drive(1'b0, '0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) probe("sat_14", SEL_STC, 14);
      if (i == 15) probe("sat_15", SEL_STC, 15);
    end
    probe("sat_20", SEL_STC, 15);
    out_ready = 1'b1;
    step();
    probe("sat_after_drain", SEL_STC, 15);
    probe("sat_drain_occ",   SEL_OCC, 0);
    step();
    step();
    done = 1'b1;
  end

endmodule

// File: doc/id_ex_skid_stage.md
# id_ex_skid_stage

Parametrised elastic pipeline register for the decode→execute boundary, and successor to the fixed-width ID/EX latch. It carries a generic payload and control word between stages under a valid/ready handshake. A 2-entry skid buffer lets it absorb downstream stalls without combinational ready paths. It adds synchronous flush (bubble insertion), a zero-control bubble guarantee and a saturating stall-cycle counter.

## Interface
- DATA_W, 101: payload width (rs1/rs2/rd indices, operand data, immediate, pc, packed by the instantiator)
- CTRL_W, 11: control word width; all-zero control is a NOP/bubble
- CNT_W, 16: width of the stall-cycle counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all held entries (branch/jump redirect)
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control word
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main payload
- out_ctrl  out  CTRL_W  main control; forced 0 when out_valid=0
- occupancy  out  2  held entries, 0..2
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- State: main {valid, data, ctrl}, skid {valid, data, ctrl}, stall_cnt. skid_valid=1 implies main_valid=1.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Update rules, no flush:
  - main empty, in_fire: main ← input.
  - main full, out_fire, skid empty: main ← input if in_fire, else main_valid ← 0.
  - main full, out_fire, skid full: main ← skid, skid_valid ← 0. in_ready is 0, so no input arrives.
  - main full, no out_fire, in_fire: skid ← input.
  - main full, no out_fire, no in_fire: hold.
- Ordering is strict FIFO. The skid entry always leaves before any newer input.
- flush=1: main_valid ← 0 and skid_valid ← 0 on that edge. Any in_fire that cycle is accepted and discarded. out_fire that cycle still counts as delivered downstream. Flush has priority over all update rules.
- Data/ctrl registers of invalid entries keep their stale values internally. out_ctrl is masked to 0 whenever main_valid=0, so downstream never sees stale regwrite/memwrite.
- occupancy = main_valid + skid_valid.
- stall_cnt increments by 1 each cycle out_valid & !out_ready. It saturates at 2^CNT_W−1 and is not cleared by flush.

## Timing
- Reset (async assert, sync release): main_valid=0, skid_valid=0, all data/ctrl registers 0, stall_cnt=0. Therefore in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- Latency: input accepted at edge N appears on out_* after edge N (1 cycle) when main is empty or draining.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready depends only on registers. There is no combinational path from out_ready or flush to in_ready.
- First stall cycle: the entry presented is captured in skid. in_ready drops after that edge.
- Stall release: skid drains the cycle after main is consumed. in_ready returns to 1 the following cycle.
- Reset mid-stream drops all entries immediately (asynchronous). out_ctrl is 0 from reset assertion.

## Test plan
- Streaming: out_ready=1, feed ctrl 0x001..0x00A on consecutive cycles. Each value appears on out_ctrl exactly one cycle later, in order. occupancy stays 1. stall_cnt stays 0.
- Stall/skid: feed A,B,C with out_ready=0 from cycle of B. Result: main=A, skid=B, in_ready=0, C held upstream. Raise out_ready and observe A, B, C on consecutive cycles. stall_cnt equals the number of stalled cycles.
- Flush with full buffer: occupancy=2, pulse flush with in_valid=1 (ctrl 0x7FF). Next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. The 0x7FF entry never appears on the output.
- Bubble masking: accept ctrl 0x7FF, consume it, then idle. out_ctrl=0x000 while out_valid=0.
- Async reset mid-operation: assert rst between edges with occupancy=2. Outputs go to reset values immediately. After release, first accepted input appears with 1-cycle latency.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles. stall_cnt reads 15 and stays 15.
